// File: rtl/picorv32_pcpi_issue_if.sv
// Core-side request/response and coprocessor-side PCPI signals of the issue block.
interface picorv32_pcpi_issue_if;
    localparam int unsigned XLEN = 32;

    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_insn;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;

    logic            resp_valid;
    logic            resp_ready;
    logic            resp_wr;
    logic [XLEN-1:0] resp_rd;
    logic            resp_illegal;

    logic            pcpi_valid;
    logic [XLEN-1:0] pcpi_insn;
    logic [XLEN-1:0] pcpi_rs1;
    logic [XLEN-1:0] pcpi_rs2;
    logic            pcpi_wr;
    logic [XLEN-1:0] pcpi_rd;
    logic            pcpi_wait;
    logic            pcpi_ready;

    // Issue block view: serves the core, drives the coprocessor.
    modport slave (
        input  flush, req_valid, req_insn, req_rs1, req_rs2, resp_ready,
               pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        output req_ready, resp_valid, resp_wr, resp_rd, resp_illegal,
               pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
    );

    // Core/coprocessor view.
    modport master (
        output flush, req_valid, req_insn, req_rs1, req_rs2, resp_ready,
               pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
        input  req_ready, resp_valid, resp_wr, resp_rd, resp_illegal,
               pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
    );
endinterface

// File: rtl/picorv32_pcpi_issue.sv
// Issues one instruction at a time to a PCPI coprocessor and returns its
// result, or an illegal-instruction response if the coprocessor stays silent.
module picorv32_pcpi_issue #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    picorv32_pcpi_issue_if.slave   bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               accept_c;
    logic               issue_c;
    logic               tmo_expired_c;

    // Qualifiers shared by the FSM and the datapath; flush masks everything.
    assign accept_c      = (state == S_IDLE) && bus.req_valid && !bus.flush;
    assign issue_c       = (state == S_ISSUE) && !bus.flush;
    assign tmo_expired_c = !bus.pcpi_ready && !bus.pcpi_wait
                           && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: flush wins, then pcpi_ready beats the timeout.
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.req_valid) state_nxt = S_ISSUE;
                S_ISSUE: if (bus.pcpi_ready || tmo_expired_c) state_nxt = S_RESP;
                S_RESP:  if (bus.resp_ready) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state so async reset clears them at once.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.pcpi_valid = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            S_IDLE:  bus.req_ready  = 1'b1;
            S_ISSUE: bus.pcpi_valid = 1'b1;
            S_RESP:  bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Silence counter: restarts on accept and on pcpi_wait, saturates otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (accept_c) begin
            tmo_cnt <= '0;
        end else if (issue_c && !bus.pcpi_ready) begin
            if (bus.pcpi_wait)
                tmo_cnt <= '0;
            else if (!tmo_expired_c && (tmo_cnt != {CNT_W{1'b1}}))
                tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // Operand latch, held for the whole issue phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pcpi_insn <= '0;
            bus.pcpi_rs1  <= '0;
            bus.pcpi_rs2  <= '0;
        end else if (accept_c) begin
            bus.pcpi_insn <= bus.req_insn;
            bus.pcpi_rs1  <= bus.req_rs1;
            bus.pcpi_rs2  <= bus.req_rs2;
        end
    end

    // Response latch: coprocessor result, or an illegal marker on timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.resp_wr      <= 1'b0;
            bus.resp_rd      <= '0;
            bus.resp_illegal <= 1'b0;
        end else if (issue_c && bus.pcpi_ready) begin
            bus.resp_wr      <= bus.pcpi_wr;
            bus.resp_rd      <= bus.pcpi_rd;
            bus.resp_illegal <= 1'b0;
        end else if (issue_c && tmo_expired_c) begin
            bus.resp_wr      <= 1'b0;
            bus.resp_rd      <= '0;
            bus.resp_illegal <= 1'b1;
        end
    end
endmodule

// File: tb/tb_picorv32_pcpi_issue.sv
// Directed bench for picorv32_pcpi_issue with a behavioural PCPI multiplier.
module tb_picorv32_pcpi_issue;
    localparam int unsigned TIMEOUT     = 16;
    localparam int          MODE_MUL    = 0;
    localparam int          MODE_SILENT = 1;
    localparam int          MODE_RACE   = 2;

    typedef struct {
        logic        wr;
        logic [31:0] rd;
        logic        ill;
    } exp_t;

    logic clk;
    logic reset;
    picorv32_pcpi_issue_if bus();

    picorv32_pcpi_issue #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          mode     = MODE_SILENT;
    int          lat      = 4;
    logic [31:0] last_insn;
    exp_t        sb[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mul_res(input logic [31:0] insn,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return (insn[14:12] == 3'd3) ? p[63:32] : p[31:0];
    endfunction

    // Coprocessor: drives its reply just after each rising edge.
    initial begin
        int busy;
        busy = 0;
        bus.pcpi_wr = 1'b0; bus.pcpi_rd = '0; bus.pcpi_wait = 1'b0; bus.pcpi_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.pcpi_wr = 1'b0; bus.pcpi_rd = '0; bus.pcpi_wait = 1'b0; bus.pcpi_ready = 1'b0;
            if (bus.pcpi_valid !== 1'b1) begin
                busy = 0;
            end else begin
                busy++;
                if ((mode == MODE_MUL && busy >= lat) ||
                    (mode == MODE_RACE && busy == int'(TIMEOUT))) begin
                    bus.pcpi_ready = 1'b1;
                    bus.pcpi_wr    = 1'b1;
                    bus.pcpi_rd    = mul_res(bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2);
                end else if (mode == MODE_MUL) begin
                    bus.pcpi_wait = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input string tag, input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [31:0] rs2, input bit push, input logic e_wr,
                         input logic [31:0] e_rd, input logic e_ill);
        exp_t e;
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_insn = insn; bus.req_rs1 = rs1; bus.req_rs2 = rs2;
        last_insn = insn;
        if (push) begin
            e.wr = e_wr; e.rd = e_rd; e.ill = e_ill;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({tag, "_pcpi_valid"}, 32'(bus.pcpi_valid), 32'd1);
        chk({tag, "_pcpi_insn"}, bus.pcpi_insn, insn);
        chk({tag, "_pcpi_rs1"}, bus.pcpi_rs1, rs1);
        chk({tag, "_pcpi_rs2"}, bus.pcpi_rs2, rs2);
    endtask

    // Wait for the response, score it, apply bp cycles of backpressure, handshake.
    task automatic collect(input string tag, input int limit, input int bp,
                           output int cyc, output int hi, output bit saw_wait);
        exp_t e;
        int   unstable;
        logic [31:0] held_rd;
        cyc = 1; hi = 0; saw_wait = 1'b0; unstable = 0;
        while (bus.resp_valid !== 1'b1 && cyc < limit) begin
            if (bus.pcpi_valid === 1'b1) hi++;
            if (bus.pcpi_wait === 1'b1) saw_wait = 1'b1;
            if (bus.pcpi_insn !== last_insn) unstable++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "_insn_stable"}, 32'(unstable), 32'd0);
        chk({tag, "_pcpi_dropped"}, 32'(bus.pcpi_valid), 32'd0);
        chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_resp_wr"}, 32'(bus.resp_wr), 32'(e.wr));
            chk({tag, "_resp_rd"}, bus.resp_rd, e.rd);
            chk({tag, "_resp_illegal"}, 32'(bus.resp_illegal), 32'(e.ill));
        end
        held_rd = bus.resp_rd;
        for (int i = 0; i < bp; i++) begin
            chk({tag, "_bp_valid"}, 32'(bus.resp_valid), 32'd1);
            chk({tag, "_bp_rd"}, bus.resp_rd, held_rd);
            chk({tag, "_bp_req_ready"}, 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk({tag, "_resp_done"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_req_ready_after"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.resp_valid !== 1'b0 || bus.pcpi_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        chk({tag, "_quiet"}, 32'(seen), 32'd0);
    endtask

    initial begin
        int cyc, hi;
        bit sw;
        reset = 1'b1;
        bus.flush = 1'b0; bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
        bus.req_insn = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_wr", 32'(bus.resp_wr), 32'd0);
        chk("rst_resp_illegal", 32'(bus.resp_illegal), 32'd0);
        chk("rst_resp_rd", bus.resp_rd, 32'd0);
        chk("rst_pcpi_insn", bus.pcpi_insn, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // MUL 3*5, short latency
        mode = MODE_MUL; lat = 4;
        issue("mul", 32'h02B50533, 32'd3, 32'd5, 1'b1, 1'b1, 32'd15, 1'b0);
        collect("mul", 60, 0, cyc, hi, sw);
        chk("mul_cycle", 32'(cyc), 32'd5);
        chk("mul_pcpi_cycles", 32'(hi), 32'd4);

        // MULHU with latency beyond the timeout, kept alive by pcpi_wait
        lat = 24;
        issue("mulhu", 32'h02B53533, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0);
        collect("mulhu", 80, 0, cyc, hi, sw);
        chk("mulhu_saw_wait", 32'(sw), 32'd1);
        chk("mulhu_cycle", 32'(cyc), 32'd25);

        // Silent coprocessor -> illegal after TIMEOUT issue cycles
        mode = MODE_SILENT;
        issue("tmo", 32'h0000000B, 32'd1, 32'd2, 1'b1, 1'b0, 32'd0, 1'b1);
        collect("tmo", 60, 0, cyc, hi, sw);
        chk("tmo_cycle", 32'(cyc), 32'd17);
        chk("tmo_pcpi_cycles", 32'(hi), 32'd16);

        // Response backpressure
        mode = MODE_MUL; lat = 3;
        issue("bp", 32'h02B50533, 32'd9, 32'd11, 1'b1, 1'b1, 32'd99, 1'b0);
        collect("bp", 60, 5, cyc, hi, sw);

        // pcpi_ready on the very cycle the counter reaches TIMEOUT-1
        mode = MODE_RACE;
        issue("race", 32'h02B50533, 32'd12345, 32'd2, 1'b1, 1'b1, 32'd24690, 1'b0);
        collect("race", 60, 0, cyc, hi, sw);
        chk("race_cycle", 32'(cyc), 32'd17);

        // Flush in IDLE blocks acceptance
        bus.flush = 1'b1; bus.req_valid = 1'b1; bus.req_insn = 32'h02B50533;
        @(negedge clk);
        bus.flush = 1'b0; bus.req_valid = 1'b0;
        chk("flush_idle_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
        chk("flush_idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Flush mid-ISSUE
        mode = MODE_SILENT;
        issue("flush", 32'h02B50533, 32'd4, 32'd4, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
        chk("flush_req_ready", 32'(bus.req_ready), 32'd1);
        quiet("flush", 24);
        mode = MODE_MUL; lat = 4;
        issue("flush_mul", 32'h02B50533, 32'd7, 32'd6, 1'b1, 1'b1, 32'd42, 1'b0);
        collect("flush_mul", 60, 0, cyc, hi, sw);

        // Reset mid-ISSUE
        mode = MODE_SILENT;
        issue("areset", 32'h02B50533, 32'd8, 32'd8, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("areset_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
        chk("areset_pcpi_insn", bus.pcpi_insn, 32'd0);
        chk("areset_resp_rd", bus.resp_rd, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        quiet("areset", 24);
        mode = MODE_MUL; lat = 4;
        issue("areset_mul", 32'h02B50533, 32'd7, 32'd6, 1'b1, 1'b1, 32'd42, 1'b0);
        collect("areset_mul", 60, 0, cyc, hi, sw);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/picorv32_pcpi_issue.md
PICORV32_PCPI_ISSUE -- requirements
Module: picorv32_pcpi_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of consecutive ISSUE cycles with pcpi_wait and pcpi_ready both low before an illegal-instruction response is given (legal range 2..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous abort of any outstanding request.
REQ-005 SHALL have port req_valid  input  1  the core presents an instruction.
REQ-006 SHALL have port req_ready  output  1  the block accepts an instruction this cycle.
REQ-007 SHALL have port req_insn, req_rs1, req_rs2  input  32 each  the instruction word and its operands.
REQ-008 SHALL have port resp_valid  output  1  a response is held.
REQ-009 SHALL have port resp_ready  input  1  the core consumes the response.
REQ-010 SHALL have ports resp_wr  output  1, resp_rd  output  32 and resp_illegal  output  1  the write-enable, result and timeout flag.
REQ-011 SHALL have ports pcpi_valid  output  1 and pcpi_insn, pcpi_rs1, pcpi_rs2  output  32 each  the coprocessor request.
REQ-012 SHALL have ports pcpi_wr  input  1, pcpi_rd  input  32, pcpi_wait  input  1 and pcpi_ready  input  1  the coprocessor reply.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, ISSUE and RESP.
REQ-014 SHALL drive req_ready = 1 only in IDLE, combinationally from state, with no dependency on req_valid.
REQ-015 SHALL, on a cycle where req_valid && req_ready, register req_insn, req_rs1 and req_rs2 into pcpi_insn, pcpi_rs1 and pcpi_rs2, clear the timeout counter and enter ISSUE.
REQ-016 SHALL assert pcpi_valid exactly while in ISSUE, so it first rises on the cycle after acceptance.
REQ-017 SHALL hold pcpi_insn, pcpi_rs1 and pcpi_rs2 stable for the whole of ISSUE.
REQ-018 SHALL, in ISSUE with pcpi_ready = 1, capture pcpi_wr into resp_wr and pcpi_rd into resp_rd, clear resp_illegal and enter RESP; pcpi_ready has priority over the timeout on the same cycle.
REQ-019 SHALL, in ISSUE with pcpi_ready = 0 and pcpi_wait = 1, clear the timeout counter and remain in ISSUE for unbounded time.
REQ-020 SHALL, in ISSUE with pcpi_ready = 0 and pcpi_wait = 0, enter RESP with resp_illegal = 1, resp_wr = 0 and resp_rd = 0 when the counter equals TIMEOUT-1; otherwise it SHALL increment the counter.
REQ-021 SHALL use a timeout counter of 8 bits that never wraps.
REQ-022 SHALL assert resp_valid exactly while in RESP and hold resp_wr, resp_rd and resp_illegal stable until the handshake.
REQ-023 SHALL, in RESP with resp_ready = 1, return to IDLE on the next edge, so a new request can be accepted one cycle after the response handshake.
REQ-024 SHALL ignore pcpi_ready, pcpi_wait, pcpi_wr and pcpi_rd in IDLE and RESP.
REQ-025 SHALL make flush = 1 in any state force IDLE on the next edge; pcpi_valid and resp_valid SHALL be 0 from that edge, and flush SHALL take priority over all other transitions.
REQ-026 SHALL, with flush = 1 in IDLE and req_valid = 1, not accept the request.
REQ-027 SHALL drop pcpi_valid on the edge that leaves ISSUE, with no extra cycle of pcpi_valid after pcpi_ready.

Reset
REQ-028 SHALL, while reset = 1, asynchronously force state IDLE and a counter of 0.
REQ-029 SHALL, while reset = 1, force pcpi_valid, resp_valid, resp_wr and resp_illegal to 0 and pcpi_insn, pcpi_rs1, pcpi_rs2 and resp_rd to 0.
REQ-030 SHALL, on reset asserted mid-ISSUE, drop pcpi_valid immediately without waiting for a clock edge.
REQ-031 SHALL, on reset asserted mid-ISSUE, produce no response after release.
REQ-032 SHALL be ready to accept a request on the first edge after reset deasserts (req_ready = 1).

Verification
REQ-033 SHALL cover MUL with the existing picorv32 PCPI multiplier attached: insn 0x02B50533, rs1 = 3, rs2 = 5 -> pcpi_valid high from cycle 1 until pcpi_ready, then resp_valid with resp_wr = 1, resp_rd = 15, resp_illegal = 0.
REQ-034 SHALL cover MULHU with rs1 = rs2 = 0xFFFFFFFF -> resp_rd = 0xFFFFFFFE, with pcpi_wait seen high and no timeout despite the latency exceeding 16 cycles.
REQ-035 SHALL cover timeout with TIMEOUT = 16 and a responder that never asserts pcpi_wait or pcpi_ready, accepted at cycle 0 -> pcpi_valid high for cycles 1-16, resp_valid at cycle 17 with resp_illegal = 1, resp_wr = 0 and resp_rd = 0.
REQ-036 SHALL cover backpressure: resp_ready held 0 for 5 cycles -> resp_valid and resp_rd stable for all 5 cycles, req_ready = 0 throughout, and req_ready = 1 one cycle after the handshake.
REQ-037 SHALL cover the ready/timeout race: pcpi_ready = 1 on the same cycle the counter reaches TIMEOUT-1 -> a normal response with resp_illegal = 0.
REQ-038 SHALL cover abort: flush pulsed during ISSUE, and separately reset pulsed during ISSUE -> pcpi_valid = 0 from the next edge (flush) or immediately (reset), no resp_valid, and a subsequent MUL 7*6 returns 42.
